// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and oversampling constants.
// The transmit path imports the same package.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } rx_state_t;

  // Ticks per bit period at 16x oversampling.
  localparam int OVERSAMPLE = 16;
  // Tick count within the start bit at which its centre is sampled.
  localparam int MID_START  = 7;

endpackage : uart_pkg

// File: rtl/rx_fifo.sv
// Receive byte FIFO: synchronous, first-word fall-through head register,
// full/empty derived from pointers carrying one extra wrap bit.
module rx_fifo #(
  parameter int DBIT       = 8,
  parameter int ADDR_WIDTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic [DBIT-1:0] w_data,
  input  logic            pop,
  output logic [DBIT-1:0] r_data,
  output logic            empty,
  output logic            full
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DBIT-1:0]       mem_r [DEPTH];
  logic [ADDR_WIDTH:0]   wr_ptr_r;
  logic [ADDR_WIDTH:0]   rd_ptr_r;
  logic [ADDR_WIDTH:0]   count_s;
  logic [ADDR_WIDTH-1:0] rd_next_idx_s;
  logic [DBIT-1:0]       head_r;
  logic [DBIT-1:0]       head_next_s;
  logic                  wr_en_s;
  logic                  rd_en_s;

  assign count_s       = wr_ptr_r - rd_ptr_r;
  assign empty         = (wr_ptr_r == rd_ptr_r);
  assign full          = (wr_ptr_r[ADDR_WIDTH] != rd_ptr_r[ADDR_WIDTH]) &&
                         (wr_ptr_r[ADDR_WIDTH-1:0] == rd_ptr_r[ADDR_WIDTH-1:0]);
  // A pop on an empty FIFO is ignored; a push into a full FIFO only lands
  // when a pop frees the head slot in the same cycle.
  assign rd_en_s       = pop & ~empty;
  assign wr_en_s       = push & (~full | rd_en_s);
  assign rd_next_idx_s = rd_ptr_r[ADDR_WIDTH-1:0] + ADDR_WIDTH'(1);
  assign r_data        = head_r;

  // Next head value: the new byte when it lands in an empty (or emptying)
  // FIFO, the following entry after a pop, otherwise the last head is held.
  always_comb begin
    head_next_s = head_r;
    if (empty) begin
      if (push) begin
        head_next_s = w_data;
      end else begin
        head_next_s = head_r;
      end
    end else if (rd_en_s) begin
      if (count_s == (ADDR_WIDTH+1)'(1)) begin
        if (push) begin
          head_next_s = w_data;
        end else begin
          head_next_s = head_r;
        end
      end else begin
        head_next_s = mem_r[rd_next_idx_s];
      end
    end else begin
      head_next_s = head_r;
    end
  end

  // Read/write pointers and the registered head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      head_r   <= '0;
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + (ADDR_WIDTH+1)'(1);
      end
      if (rd_en_s) begin
        rd_ptr_r <= rd_ptr_r + (ADDR_WIDTH+1)'(1);
      end
      head_r <= head_next_s;
    end
  end

  // Storage array write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (wr_en_s) begin
      mem_r[wr_ptr_r[ADDR_WIDTH-1:0]] <= w_data;
    end
  end

endmodule : rx_fifo

// File: rtl/uart_rx_unit.sv
// UART receiver: two-flop rx synchroniser, 16x oversampled deserialiser FSM,
// receive FIFO, and single-cycle frame-error / overrun pulses.
module uart_rx_unit
  import uart_pkg::*;
#(
  parameter int DBIT       = 8,
  parameter int SB_TICK    = 16,
  parameter int ADDR_WIDTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  input  logic            s_tick,
  input  logic            rd_uart,
  output logic [DBIT-1:0] r_data,
  output logic            rx_empty,
  output logic            rx_full,
  output logic            frame_err,
  output logic            overrun
);

  localparam int N_W = (DBIT > 1) ? $clog2(DBIT) : 1;
  // Two stop bits need a wider tick counter than one bit period.
  localparam int S_W = (SB_TICK > OVERSAMPLE) ? $clog2(SB_TICK) : 4;

  logic            sync1_r;
  logic            rx_s;
  rx_state_t       state_r, state_next_s;
  logic [S_W-1:0]  s_r, s_next_s;
  logic [N_W-1:0]  n_r, n_next_s;
  logic [DBIT-1:0] b_r, b_next_s;
  logic            rx_done_s;
  logic            frame_err_s;
  logic            overrun_s;
  logic            frame_err_r;
  logic            overrun_r;

  // Bring the asynchronous line into the clk domain; idle level is high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_r <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      sync1_r <= rx;
      rx_s    <= sync1_r;
    end
  end

  // Deserialiser state, tick counter, bit counter and shift register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      s_r     <= '0;
      n_r     <= '0;
      b_r     <= '0;
    end else begin
      state_r <= state_next_s;
      s_r     <= s_next_s;
      n_r     <= n_next_s;
      b_r     <= b_next_s;
    end
  end

  // Frame decoding: only the start-edge detection ignores s_tick.
  always_comb begin
    state_next_s = state_r;
    s_next_s     = s_r;
    n_next_s     = n_r;
    b_next_s     = b_r;
    rx_done_s    = 1'b0;
    frame_err_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (!rx_s) begin
          state_next_s = START;
          s_next_s     = '0;
        end else begin
          state_next_s = IDLE;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_r == S_W'(MID_START)) begin
            if (!rx_s) begin
              state_next_s = DATA;
              s_next_s     = '0;
              n_next_s     = '0;
            end else begin
              // Line back high at mid start bit: treat as a glitch.
              state_next_s = IDLE;
            end
          end else begin
            s_next_s = s_r + S_W'(1);
          end
        end else begin
          state_next_s = START;
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_r == S_W'(OVERSAMPLE - 1)) begin
            b_next_s = {rx_s, b_r[DBIT-1:1]};
            s_next_s = '0;
            if (n_r == N_W'(DBIT - 1)) begin
              state_next_s = STOP;
            end else begin
              n_next_s = n_r + N_W'(1);
            end
          end else begin
            s_next_s = s_r + S_W'(1);
          end
        end else begin
          state_next_s = DATA;
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_r == S_W'(SB_TICK - 1)) begin
            if (rx_s) begin
              rx_done_s = 1'b1;
            end else begin
              frame_err_s = 1'b1;
            end
            state_next_s = IDLE;
          end else begin
            s_next_s = s_r + S_W'(1);
          end
        end else begin
          state_next_s = STOP;
        end
      end
      default: begin
        state_next_s = IDLE;
        s_next_s     = '0;
        n_next_s     = '0;
      end
    endcase
  end

  // A completed byte is lost only when the FIFO is full and nobody pops now.
  assign overrun_s = rx_done_s & rx_full & ~rd_uart;

  // Register the status pulses so they leave the block glitch-free.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      frame_err_r <= frame_err_s;
      overrun_r   <= overrun_s;
    end
  end

  assign frame_err = frame_err_r;
  assign overrun   = overrun_r;

  rx_fifo #(
    .DBIT       (DBIT),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_rx_fifo (
    .clk    (clk),
    .rst_n  (reset),
    .push   (rx_done_s),
    .w_data (b_r),
    .pop    (rd_uart),
    .r_data (r_data),
    .empty  (rx_empty),
    .full   (rx_full)
  );

endmodule : uart_rx_unit
